// File: rtl/rvc_inst_aligner.sv
// Splits word-aligned 32-bit fetch words into 16/32-bit instructions for the RVC decoder.
// Latency: a word accepted at edge N shows its first instruction on dec_* after edge N+1.
// Backpressure: dec_* holds while !dec_ready_i; fetch_ready_o drops until the buffered word is consumed.
module rvc_inst_aligner #(
    parameter int PC_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_valid_i,
    output logic                fetch_ready_o,
    input  logic [31:0]         fetch_data_i,
    input  logic [PC_WIDTH-1:0] fetch_pc_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic                dec_valid_o,
    input  logic                dec_ready_i,
    output logic [31:0]         dec_inst_o,
    output logic                dec_is_rv_o,
    output logic [PC_WIDTH-1:0] dec_pc_o
);

    logic                wb_valid;
    logic [31:0]         wb_data;
    logic [PC_WIDTH-1:0] wb_pc;
    logic                wb_ptr;
    logic                hold_valid;
    logic [15:0]         hold_hw;
    logic [PC_WIDTH-1:0] hold_pc;
    logic                skip_lo;

    logic                out_free;
    logic [15:0]         lo_hw;
    logic [15:0]         hi_hw;
    logic                lo_rv;
    logic                hi_rv;
    logic [PC_WIDTH-1:0] pc_plus2;

    logic                emit;
    logic [31:0]         emit_inst;
    logic                emit_rv;
    logic [PC_WIDTH-1:0] emit_pc;
    logic                consume;
    logic                hold_move;
    logic                take_hold;
    logic                adv_ptr;
    logic                fetch_fire;

    // Only the halfword-offset bit of the redirect target matters here.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^{redirect_pc_i[PC_WIDTH-1:2], redirect_pc_i[0]};

    assign out_free = !dec_valid_o || dec_ready_i;
    assign lo_hw    = wb_data[15:0];
    assign hi_hw    = wb_data[31:16];
    assign lo_rv    = (lo_hw[1:0] == 2'b11);
    assign hi_rv    = (hi_hw[1:0] == 2'b11);
    assign pc_plus2 = wb_pc + PC_WIDTH'(2);

    always_comb begin
        emit      = 1'b0;
        emit_inst = 32'h0;
        emit_rv   = 1'b0;
        emit_pc   = '0;
        consume   = 1'b0;
        hold_move = 1'b0;
        take_hold = 1'b0;
        adv_ptr   = 1'b0;
        if (wb_valid) begin
            if (hold_valid) begin
                // Second half of a straddling instruction lives in the low half of this word.
                if (out_free) begin
                    emit      = 1'b1;
                    emit_inst = {lo_hw, hold_hw};
                    emit_rv   = 1'b1;
                    emit_pc   = hold_pc;
                    take_hold = 1'b1;
                    adv_ptr   = 1'b1;
                end
            end else if (!wb_ptr) begin
                if (out_free) begin
                    emit    = 1'b1;
                    emit_pc = wb_pc;
                    if (lo_rv) begin
                        emit_inst = wb_data;
                        emit_rv   = 1'b1;
                        consume   = 1'b1;
                    end else begin
                        emit_inst = {16'h0, lo_hw};
                        adv_ptr   = 1'b1;
                    end
                end
            end else if (hi_rv) begin
                // Parking the low half needs no output slot, so it ignores backpressure.
                hold_move = 1'b1;
                consume   = 1'b1;
            end else if (out_free) begin
                emit      = 1'b1;
                emit_inst = {16'h0, hi_hw};
                emit_pc   = pc_plus2;
                consume   = 1'b1;
            end
        end
    end

    assign fetch_ready_o = !rst && !redirect_i && (!wb_valid || consume);
    assign fetch_fire    = fetch_valid_i && fetch_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_data     <= 32'h0;
            wb_pc       <= '0;
            wb_ptr      <= 1'b0;
            hold_valid  <= 1'b0;
            hold_hw     <= 16'h0;
            hold_pc     <= '0;
            skip_lo     <= 1'b0;
            dec_valid_o <= 1'b0;
            dec_inst_o  <= 32'h0;
            dec_is_rv_o <= 1'b0;
            dec_pc_o    <= '0;
        end else if (redirect_i) begin
            wb_valid    <= 1'b0;
            hold_valid  <= 1'b0;
            dec_valid_o <= 1'b0;
            skip_lo     <= redirect_pc_i[1];
        end else begin
            if (emit) begin
                dec_valid_o <= 1'b1;
                dec_inst_o  <= emit_inst;
                dec_is_rv_o <= emit_rv;
                dec_pc_o    <= emit_pc;
            end else if (out_free) begin
                dec_valid_o <= 1'b0;
            end

            if (take_hold) begin
                hold_valid <= 1'b0;
            end else if (hold_move) begin
                hold_valid <= 1'b1;
                hold_hw    <= hi_hw;
                hold_pc    <= pc_plus2;
            end

            if (adv_ptr) begin
                wb_ptr <= 1'b1;
            end

            // A new word overrides any pointer update from the word it replaces.
            if (fetch_fire) begin
                wb_valid <= 1'b1;
                wb_data  <= fetch_data_i;
                wb_pc    <= fetch_pc_i;
                wb_ptr   <= skip_lo;
                skip_lo  <= 1'b0;
            end else if (consume) begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvc_inst_aligner.sv
// Self-checking bench for rvc_inst_aligner: table of single words plus straddle/redirect/backpressure sequences.
// Latency: outputs are matched against a scoreboard queue filled when each word is driven.
// Backpressure: dec_ready_i is toggled by the bench; handshakes are sampled on the falling edge.
module tb_rvc_inst_aligner;

    typedef struct packed {
        logic [31:0] inst;
        logic        rv;
        logic [63:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [63:0] pc;
        int          stall;
        int          n;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [63:0] fetch_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic        dec_is_rv;
    logic [63:0] dec_pc;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    vec_t vecs[6];

    rvc_inst_aligner #(.PC_WIDTH(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid_i (fetch_valid),
        .fetch_ready_o (fetch_ready),
        .fetch_data_i  (fetch_data),
        .fetch_pc_i    (fetch_pc),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .dec_valid_o   (dec_valid),
        .dec_ready_i   (dec_ready),
        .dec_inst_o    (dec_inst),
        .dec_is_rv_o   (dec_is_rv),
        .dec_pc_o      (dec_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic rv, input logic [63:0] pc);
        exp_t e;
        e.inst = inst;
        e.rv   = rv;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [63:0] pc, output int waits);
        fetch_valid = 1'b1;
        fetch_data  = d;
        fetch_pc    = pc;
        waits       = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_ready) begin
                waits = i;
                break;
            end
        end
        if (waits < 0) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %h never accepted, expected acceptance", d);
        end else begin
            @(posedge clk);
            #1;
        end
        fetch_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        repeat (4) @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        vecs[0] = '{32'h00A00093, 64'h1000, 0, 1, '{32'h00A00093, 1'b1, 64'h1000}, '{32'h0, 1'b0, 64'h0}};
        vecs[1] = '{32'h45050505, 64'h2000, 0, 2, '{32'h00000505, 1'b0, 64'h2000}, '{32'h00004505, 1'b0, 64'h2002}};
        vecs[2] = '{32'h00000001, 64'h2004, 1, 2, '{32'h00000001, 1'b0, 64'h2004}, '{32'h00000000, 1'b0, 64'h2006}};
        vecs[3] = '{32'hFFFFFFFF, 64'h5000, 1, 1, '{32'hFFFFFFFF, 1'b1, 64'h5000}, '{32'h0, 1'b0, 64'h0}};
        vecs[4] = '{32'h00028082, 64'h5004, 0, 2, '{32'h00008082, 1'b0, 64'h5004}, '{32'h00000002, 1'b0, 64'h5006}};
        vecs[5] = '{32'h45050505, 64'hFFFF_FFFF_FFFF_FFFC, 1, 2,
                    '{32'h00000505, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC}, '{32'h00004505, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE}};

        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_data  = 32'h0;
        fetch_pc    = 64'h0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        dec_ready   = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!rst && dec_valid && dec_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out: got inst %h pc %h, expected no output", dec_inst, dec_pc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("out_inst", 64'(dec_inst), 64'(e.inst));
                        check("out_is_rv", 64'(dec_is_rv), 64'(e.rv));
                        check("out_pc", dec_pc, e.pc);
                    end
                end
            end
        join_none

        // Reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
        end
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_dec_inst", 64'(dec_inst), 64'd0);
        check("rst_dec_is_rv", 64'(dec_is_rv), 64'd0);
        check("rst_dec_pc", dec_pc, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_fetch_ready", 64'(fetch_ready), 64'd1);
        @(posedge clk);
        #1;

        // Table of self-contained words, fed back to back
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].e0.inst, vecs[i].e0.rv, vecs[i].e0.pc);
            if (vecs[i].n == 2) push(vecs[i].e1.inst, vecs[i].e1.rv, vecs[i].e1.pc);
            send_word(vecs[i].data, vecs[i].pc, w);
            check($sformatf("vec%0d_stall", i), 64'(w), 64'(vecs[i].stall));
        end
        drain();

        // Straddling 32-bit instruction
        push(32'h00004505, 1'b0, 64'h3000);
        send_word(32'h00934505, 64'h3000, w);
        push(32'h00A00093, 1'b1, 64'h3002);
        push(32'h00004505, 1'b0, 64'h3006);
        send_word(32'h450500A0, 64'h3004, w);
        drain();

        // Halfword redirect drops a parked half; redirect blocks a simultaneous fetch
        push(32'h00004505, 1'b0, 64'h3800);
        send_word(32'h00934505, 64'h3800, w);
        repeat (4) @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 64'h4002;
        fetch_valid = 1'b1;
        fetch_data  = 32'h45050001;
        fetch_pc    = 64'h4000;
        @(negedge clk);
        check("redirect_fetch_ready", 64'(fetch_ready), 64'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        push(32'h00004505, 1'b0, 64'h4002);
        send_word(32'h45050001, 64'h4000, w);
        drain();

        // Backpressure: outputs stable, fetch stalls, nothing lost after release
        dec_ready = 1'b0;
        push(32'h00000505, 1'b0, 64'h6000);
        push(32'h00004505, 1'b0, 64'h6002);
        push(32'h00A00093, 1'b1, 64'h6004);
        send_word(32'h45050505, 64'h6000, w);
        fetch_valid = 1'b1;
        fetch_data  = 32'h00A00093;
        fetch_pc    = 64'h6004;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_dec_valid", 64'(dec_valid), 64'd1);
            check("bp_dec_inst", 64'(dec_inst), 64'h505);
            check("bp_dec_pc", dec_pc, 64'h6000);
            check("bp_fetch_ready", 64'(fetch_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        dec_ready = 1'b1;
        send_word(32'h00A00093, 64'h6004, w);
        drain();

        // Reset mid-operation discards in-flight data
        dec_ready = 1'b0;
        send_word(32'hFFFFFFFF, 64'h7000, w);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dec_valid", 64'(dec_valid), 64'd0);
        check("midrst_fetch_ready", 64'(fetch_ready), 64'd1);
        dec_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rvc_inst_aligner.md
# rvc_inst_aligner

Instruction realigner between the fetch unit and `rvc_decoder`. It accepts 32-bit word-aligned fetch words and splits them into individual 16-bit (RVC) or 32-bit (RV) instructions, including 32-bit instructions that straddle two fetch words. It presents one instruction per handshake, with its PC and an `is_rv` flag, driving `rvc_decoder.instruction_i` / `is_rv_i` directly. It also handles pipeline redirects, including redirect targets on a halfword offset.

## Interface
- `PC_WIDTH`, default 64: width of all PC fields.
- `clk` in 1: clock. One clock domain; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `fetch_valid_i` in 1: fetch word valid.
- `fetch_ready_o` out 1: aligner accepts a fetch word this cycle.
- `fetch_data_i` in 32: fetch word, little-endian halfwords.
- `fetch_pc_i` in PC_WIDTH: fetch word PC; bits [1:0] are always 0.
- `redirect_i` in 1: flush all buffered state.
- `redirect_pc_i` in PC_WIDTH: redirect target; only bit [1] is used here.
- `dec_valid_o` out 1: instruction valid toward the decoder.
- `dec_ready_i` in 1: downstream accepts the instruction.
- `dec_inst_o` out 32: instruction. For RVC it is {16'h0, halfword}; for RV it is the full 32 bits.
- `dec_is_rv_o` out 1: 1 = 32-bit instruction; drives `is_rv_i`.
- `dec_pc_o` out PC_WIDTH: instruction PC.

## Operation
- **State:**
  - word buffer: `wb_valid`, `wb_data[31:0]`, `wb_pc`, `wb_ptr` (0 = next halfword is [15:0], 1 = next is [31:16]).
  - hold register: `hold_valid`, `hold_hw[15:0]`, `hold_pc`. Holds the low half of a straddling 32-bit instruction.
  - `skip_lo` flag.
  - output register driving all `dec_*` outputs.
- **Instruction length:** a halfword is RV (low half of a 32-bit instruction) iff its bits [1:0] == 2'b11; otherwise it is RVC.
- **Extraction.** Evaluated each cycle, only when `out_free = !dec_valid_o || dec_ready_i`. Rules in priority order:
  1. `hold_valid && wb_valid`: emit {`wb_data[15:0]`, `hold_hw`}, `is_rv`=1, pc=`hold_pc`. Clear `hold_valid`; set `wb_ptr`=1.
  2. `wb_valid`, `wb_ptr`=0, low half RVC: emit the low half, pc=`wb_pc`; set `wb_ptr`=1.
  3. `wb_valid`, `wb_ptr`=0, low half RV: emit `wb_data`, `is_rv`=1, pc=`wb_pc`. Word consumed.
  4. `wb_valid`, `wb_ptr`=1, high half RVC: emit the high half, pc=`wb_pc`+2. Word consumed.
- **Hold move.** When `wb_valid`, `wb_ptr`=1, high half is RV and `!hold_valid`:
  - copy the high half to `hold_hw`, set `hold_pc`=`wb_pc`+2, word consumed, nothing emitted.
  - this is performed regardless of `out_free`.
- **Word consumed:** `wb_valid` clears unless a new word is loaded in the same cycle.
- **Fetch ready:** `fetch_ready_o` = !`rst` && !`redirect_i` && (!`wb_valid` || word consumed this cycle). This is a combinational path from `dec_ready_i`.
- **Word load.** On a fetch handshake:
  - `wb_data`/`wb_pc` load from the fetch inputs.
  - `wb_ptr` = `skip_lo`, then `skip_lo` clears.
- **Output register:**
  - when `out_free` and an instruction is emitted, load it and set `dec_valid_o`=1.
  - when `out_free` and nothing is emitted, `dec_valid_o`=0.
  - while `dec_valid_o` && !`dec_ready_i`, all `dec_*` outputs are held stable.
- **Redirect** has top priority. In the `redirect_i` cycle:
  - clear `wb_valid`, `hold_valid` and `dec_valid_o`, even if `dec_ready_i`=1.
  - set `skip_lo` = `redirect_pc_i[1]`.
  - no fetch handshake occurs.
  - the next accepted word is the redirect target's word.
- **PC arithmetic:** `wb_pc`+2 is computed at PC_WIDTH and wraps modulo 2^PC_WIDTH.

## Timing
- **Reset** (synchronous; all of the following hold at the first edge with `rst`=1):
  - `wb_valid`, `hold_valid`, `skip_lo`, `dec_valid_o`, `dec_is_rv_o` = 0.
  - `dec_inst_o` = 32'h0, `dec_pc_o` = 0.
  - `fetch_ready_o` = 0 while `rst` is high and 1 in the first cycle after.
- **Latency:** a word accepted at edge N produces its first instruction on `dec_*` after edge N+1.
- **Throughput:** one instruction per cycle, except a hold move costs one cycle with no emission.
- **Fetch stall:** a word with two RVC halves occupies `wb` for 2 cycles, so fetch stalls 1 cycle.
- **Reset mid-operation:** in-flight data is discarded.
- **Redirect and fetch in the same cycle:** the fetch word is not accepted.

## Test plan
- **Reset:** hold `rst` 3 cycles -> `dec_valid_o`=0, `dec_inst_o`=0, `fetch_ready_o`=0; 1 in the cycle after `rst` falls.
- **Single RV:** word 0x00A00093 @0x1000 -> one output: inst 0x00A00093, `is_rv`=1, pc 0x1000, one cycle after the following edge.
- **Two RVC:** word 0x45050505 @0x2000 -> 0x00000505 `is_rv`=0 pc 0x2000, then 0x00004505 pc 0x2002 in back-to-back cycles; `fetch_ready_o` low for 1 cycle.
- **Straddle:** words 0x00934505 @0x3000 and 0x450500A0 @0x3004 -> outputs in order:
  - 0x4505 @0x3000
  - 0x00A00093 `is_rv`=1 @0x3002
  - 0x4505 @0x3006
- **Halfword redirect:** `redirect_i` with pc 0x4002 while `hold_valid`=1, then word 0x45050001 @0x4000 -> stale hold dropped; the only output is 0x4505 @0x4002.
- **Backpressure:** `dec_ready_i`=0 for 3 cycles with `dec_valid_o`=1 -> `dec_*` outputs stable; `fetch_ready_o`=0 once `wb` is full; no instruction lost or duplicated after release.
